dmem_req_ctrl: RTL and testbench
================================

# dmem_req_ctrl

Data-memory request controller for the M stage. It converts the M-stage load/store into a single SRAM-like bus transaction and holds the pipeline with `dmem_busy` until that transaction completes. `dmem_busy` is the `idmem.dmem_busy` input of the stall/flush unit, and the controller consumes that unit's `stall.m` in return. It also keeps the returned load data valid while M is frozen for unrelated reasons, and guarantees the access is never issued twice.

## Interface
- No parameters; address and data are 32 bits and the size code is 2 bits.
- `clk` in 1: core clock. All state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `m_req` in 1: the M-stage instruction is a valid load or store.
- `m_wr` in 1: 1 = store, 0 = load.
- `m_size` in 2: 0 = byte, 1 = half, 2 = word. Value 3 is reserved.
- `m_addr` in 32: physical address.
- `m_wdata` in 32: store data, already lane-aligned.
- `m_cancel` in 1: exception or ERET at M. Suppresses issue.
- `pipe_stall` in 1: `stall.m` from the hazard unit.
- `dmem_busy` out 1: M must stall.
- `m_rdata` out 32: load result for the M/W register.
- `data_req` out 1: bus request.
- `data_wr` out 1: bus write flag.
- `data_size` out 2: bus access size.
- `data_addr` out 32: bus address.
- `data_wdata` out 32: bus write data.
- `data_addr_ok` in 1: bus has accepted the request.
- `data_data_ok` in 1: bus response is valid (reads and writes).
- `data_rdata` in 32: bus read data.

## Operation
States:
- IDLE
- REQ: request presented, waiting for `data_addr_ok`.
- WAIT: address accepted, waiting for `data_data_ok`.
- DONE: access complete, instruction still held in M.

Issue condition: `start = (state==IDLE) && m_req && !m_cancel`.

Bus outputs:
- In IDLE with `start`, the bus outputs are combinational copies of the `m_*` fields and `data_req=1`. They are captured into the request registers on the same edge.
- In REQ, the bus outputs come from the request registers and `data_req=1`.
- In every other case `data_req=0`.

Transitions:
- IDLE → WAIT when `start && data_addr_ok`.
- IDLE → REQ when `start && !data_addr_ok`.
- IDLE → IDLE otherwise.
- REQ → WAIT on `data_addr_ok`. `m_cancel` is ignored in REQ: an offered request is never withdrawn.
- WAIT → DONE on `data_data_ok && pipe_stall`.
- WAIT → IDLE on `data_data_ok && !pipe_stall`.
- DONE → IDLE when `!pipe_stall`, i.e. the instruction leaves M, whether it advances or is flushed.

Busy signal:
- `dmem_busy = start || state==REQ || (state==WAIT && !data_data_ok)`.
- `dmem_busy` depends only on state, `m_*` and bus inputs, never on `pipe_stall`. This avoids a combinational loop through the hazard unit.

Read data:
- In WAIT with `data_data_ok` on a load, `m_rdata = data_rdata` (bypass), and `rdata_q` loads `data_rdata`.
- In all other cases, `m_rdata = rdata_q`.
- Stores never modify `rdata_q`.

Bus protocol and error rules:
- `data_data_ok` outside WAIT is ignored.
- The bus never returns `data_data_ok` in the same cycle as the `data_addr_ok` for the same transaction.
- At most one transaction is outstanding.
- A `m_size==3` request is issued unchanged. Decode must prevent it.

## Timing
- Reset (`resetn` low, asynchronous):
  - state = IDLE;
  - `rdata_q`, request registers = 0;
  - `data_req`, `dmem_busy` forced to 0 while `resetn` is low;
  - `m_rdata` = 0.
- Reset mid-transaction drops the transaction. The bus side is reset by the same `resetn`.
- Best-case latency: request in cycle 0 with `addr_ok`, `data_ok` in cycle 1. `dmem_busy` is high in cycle 0 only and low in cycle 1, where `m_rdata` is valid.
- General case: `dmem_busy` stays high from the issue cycle through the last cycle without `data_ok`. It is low in the `data_ok` cycle.
- DONE lasts exactly as long as `pipe_stall` stays high. `dmem_busy` remains 0 throughout and `m_rdata` is stable.
- The first cycle after leaving WAIT or DONE is IDLE. A back-to-back M-stage access issues in that cycle.

## Test plan
- Load hit: `m_req=1`, `m_wr=0`, addr `0x8000_0010`, `addr_ok` cycle 0, `data_ok`/rdata `0xDEAD_BEEF` cycle 1 → `data_req` only in cycle 0, `dmem_busy` = 1,0, `m_rdata=0xDEAD_BEEF` in cycle 1, IDLE in cycle 2.
- Delayed accept: `addr_ok` withheld 3 cycles → `data_req`, addr and size held constant for 4 cycles while `m_addr` is changed to garbage after cycle 0; `dmem_busy` high until `data_ok`.
- Foreign stall: `data_ok` with rdata `0x1234_5678` while `pipe_stall=1` for 5 more cycles → DONE, no second `data_req`, `m_rdata` held at `0x1234_5678`, `dmem_busy=0`; IDLE after `pipe_stall` drops.
- Cancel: `m_req=1`, `m_cancel=1` in IDLE → `data_req=0`, `dmem_busy=0`. Cancel asserted in REQ → request still completes, no re-issue.
- Store: `m_wr=1`, size 0, wdata `0x0000_00AB` → bus shows wr=1, size=0, that wdata; `m_rdata` keeps the prior load value.
- Reset in WAIT: `resetn` low mid-wait → `dmem_busy`, `data_req`, `m_rdata` all 0 immediately; a `data_ok` pulse after release is ignored.

Source files
------------

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller for the M stage.
// Turns one M-stage load/store into a single bus transaction and raises
// dmem_busy until the transaction completes. It keeps load data valid while M
// is frozen by an unrelated stall, and it never issues the same access twice.
module dmem_req_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_req,
    input  logic        m_wr,
    input  logic [1:0]  m_size,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic        m_cancel,
    input  logic        pipe_stall,
    output logic        dmem_busy,
    output logic [31:0] m_rdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_start;
    logic        w_in_req;
    logic        w_resp;
    logic        w_load_ret;

    // A new access may only start from IDLE; a cancelled instruction never reaches the bus.
    assign w_start    = (r_state == ST_IDLE) && m_req && !m_cancel;
    assign w_in_req   = (r_state == ST_REQ);
    // data_data_ok is only meaningful once the address has been accepted.
    assign w_resp     = (r_state == ST_WAIT) && data_data_ok;
    assign w_load_ret = w_resp && !r_wr;

    // The issue cycle drives the bus straight from M so a zero-wait accept costs no
    // extra cycle; afterwards the captured copy keeps the request stable even if M changes.
    assign data_req   = resetn && (w_start || w_in_req);
    assign data_wr    = w_start ? m_wr    : r_wr;
    assign data_size  = w_start ? m_size  : r_size;
    assign data_addr  = w_start ? m_addr  : r_addr;
    assign data_wdata = w_start ? m_wdata : r_wdata;

    // Busy never looks at pipe_stall: the hazard unit derives pipe_stall from busy.
    assign dmem_busy  = resetn && (w_start || w_in_req || ((r_state == ST_WAIT) && !data_data_ok));

    // Return-cycle bypass lets M/W capture the load on the very cycle the bus answers.
    assign m_rdata    = w_load_ret ? data_rdata : r_rdata;

    // Transaction sequencing, request capture and load-data retention.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_wr    <= m_wr;
                        r_size  <= m_size;
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                        r_state <= data_addr_ok ? ST_WAIT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An offered request is never withdrawn, so m_cancel is not consulted here.
                    if (data_addr_ok) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        if (!r_wr) begin
                            r_rdata <= data_rdata;
                        end
                        // Park in DONE while the instruction is still held in M so it is not reissued.
                        r_state <= pipe_stall ? ST_DONE : ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (!pipe_stall) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Testbench for dmem_req_ctrl: directed scenarios plus a randomized run checked
// against a transaction-level reference model.
module tb_dmem_req_ctrl;

    logic        clk;
    logic        resetn;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_cancel;
    logic        pipe_stall;
    logic        dmem_busy;
    logic [31:0] m_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_cmp;
    int n_fail;

    dmem_req_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_cancel     (m_cancel),
        .pipe_stall   (pipe_stall),
        .dmem_busy    (dmem_busy),
        .m_rdata      (m_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs shortly after the edge, then settle before sampling.
    task automatic drv(input logic req, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic cancel, input logic stall, input logic aok,
                       input logic dok, input logic [31:0] rdata);
        m_req = req; m_wr = wr; m_size = size; m_addr = addr; m_wdata = wdata;
        m_cancel = cancel; pipe_stall = stall; data_addr_ok = aok;
        data_data_ok = dok; data_rdata = rdata;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drv(1, 0, 2'd2, 32'h0000_1234, 32'h0, 0, 0, 1, 1, 32'hFFFF_FFFF);
        n_cmp++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%0b want=0", data_req); end
        n_cmp++; if (dmem_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b want=0", dmem_busy); end
        n_cmp++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h want=0", m_rdata); end
        tick();
        tick();
        drv(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        #2 resetn = 1'b1;
        tick();
        drv(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b0 || dmem_busy !== 1'b0 || m_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_release req=%0b busy=%0b rdata=%h want 0/0/0", data_req, dmem_busy, m_rdata);
        end
        tick();
    endtask

    task automatic test_load_hit();
        drv(1, 0, 2'd2, 32'h8000_0010, 32'h0, 0, 1, 1, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL hit_req0 got=%0b want=1", data_req); end
        n_cmp++; if (dmem_busy !== 1'b1) begin n_fail++; $display("FAIL hit_busy0 got=%0b want=1", dmem_busy); end
        n_cmp++; if (data_addr !== 32'h8000_0010 || data_wr !== 1'b0 || data_size !== 2'd2) begin
            n_fail++; $display("FAIL hit_bus addr=%h wr=%0b size=%0d want 80000010/0/2", data_addr, data_wr, data_size);
        end
        tick();
        drv(1, 0, 2'd2, 32'h8000_0010, 32'h0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        n_cmp++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL hit_req1 got=%0b want=0", data_req); end
        n_cmp++; if (dmem_busy !== 1'b0) begin n_fail++; $display("FAIL hit_busy1 got=%0b want=0", dmem_busy); end
        n_cmp++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hit_rdata1 got=%h want=deadbeef", m_rdata); end
        tick();
        drv(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b0 || dmem_busy !== 1'b0) begin
            n_fail++; $display("FAIL hit_idle2 req=%0b busy=%0b want 0/0", data_req, dmem_busy);
        end
        n_cmp++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hit_rdata2 got=%h want=deadbeef", m_rdata); end
        tick();
    endtask

    task automatic test_delayed_accept();
        drv(1, 0, 2'd1, 32'h1000_0004, 32'h0, 0, 1, 0, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b1 || dmem_busy !== 1'b1 || data_addr !== 32'h1000_0004) begin
            n_fail++; $display("FAIL dly_c0 req=%0b busy=%0b addr=%h want 1/1/10000004", data_req, dmem_busy, data_addr);
        end
        tick();
        for (int i = 1; i <= 3; i++) begin
            drv(1, 1'($urandom), 2'd3, $urandom, $urandom, 0, 1, (i == 3), 0, 32'h0);
            n_cmp++; if (data_req !== 1'b1 || dmem_busy !== 1'b1) begin
                n_fail++; $display("FAIL dly_hold%0d req=%0b busy=%0b want 1/1", i, data_req, dmem_busy);
            end
            n_cmp++; if (data_addr !== 32'h1000_0004 || data_size !== 2'd1 || data_wr !== 1'b0) begin
                n_fail++; $display("FAIL dly_bus%0d addr=%h size=%0d wr=%0b want 10000004/1/0", i, data_addr, data_size, data_wr);
            end
            tick();
        end
        drv(1, 0, 2'd1, $urandom, 32'h0, 0, 1, 0, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b0 || dmem_busy !== 1'b1) begin
            n_fail++; $display("FAIL dly_wait req=%0b busy=%0b want 0/1", data_req, dmem_busy);
        end
        tick();
        drv(1, 0, 2'd1, 32'h1000_0004, 32'h0, 0, 0, 0, 1, 32'hCAFE_0001);
        n_cmp++; if (dmem_busy !== 1'b0 || m_rdata !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL dly_resp busy=%0b rdata=%h want 0/cafe0001", dmem_busy, m_rdata);
        end
        tick();
    endtask

    task automatic test_foreign_stall();
        drv(1, 0, 2'd2, 32'h0000_0040, 32'h0, 0, 1, 1, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL fs_issue got=%0b want=1", data_req); end
        tick();
        drv(1, 0, 2'd2, 32'h0000_0040, 32'h0, 0, 1, 0, 1, 32'h1234_5678);
        n_cmp++; if (dmem_busy !== 1'b0 || m_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL fs_resp busy=%0b rdata=%h want 0/12345678", dmem_busy, m_rdata);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 2'd2, 32'h0000_0040, 32'h0, 0, 1, 1, 1, $urandom);
            n_cmp++; if (data_req !== 1'b0 || dmem_busy !== 1'b0 || m_rdata !== 32'h1234_5678) begin
                n_fail++; $display("FAIL fs_hold%0d req=%0b busy=%0b rdata=%h want 0/0/12345678", i, data_req, dmem_busy, m_rdata);
            end
            tick();
        end
        drv(1, 0, 2'd2, 32'h0000_0040, 32'h0, 0, 0, 0, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b0 || dmem_busy !== 1'b0 || m_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL fs_leave req=%0b busy=%0b rdata=%h want 0/0/12345678", data_req, dmem_busy, m_rdata);
        end
        tick();
        drv(1, 0, 2'd2, 32'h0000_0044, 32'h0, 0, 1, 1, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h0000_0044) begin
            n_fail++; $display("FAIL fs_next req=%0b addr=%h want 1/00000044", data_req, data_addr);
        end
        tick();
        drv(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h5555_AAAA);
        n_cmp++; if (m_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL fs_next_rdata got=%h want=5555aaaa", m_rdata); end
        tick();
    endtask

    task automatic test_cancel();
        drv(1, 0, 2'd2, 32'h0000_0100, 32'h0, 1, 1, 1, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b0 || dmem_busy !== 1'b0) begin
            n_fail++; $display("FAIL cxl_idle req=%0b busy=%0b want 0/0", data_req, dmem_busy);
        end
        tick();
        drv(1, 0, 2'd2, 32'h0000_0100, 32'h0, 0, 1, 0, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b1 || dmem_busy !== 1'b1) begin
            n_fail++; $display("FAIL cxl_issue req=%0b busy=%0b want 1/1", data_req, dmem_busy);
        end
        tick();
        drv(1, 0, 2'd2, 32'h0000_0100, 32'h0, 1, 1, 0, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b1 || dmem_busy !== 1'b1 || data_addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL cxl_inreq req=%0b busy=%0b addr=%h want 1/1/00000100", data_req, dmem_busy, data_addr);
        end
        tick();
        drv(1, 0, 2'd2, 32'h0000_0100, 32'h0, 1, 1, 1, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL cxl_accept got=%0b want=1", data_req); end
        tick();
        drv(1, 0, 2'd2, 32'h0000_0100, 32'h0, 1, 0, 0, 1, 32'h0BAD_F00D);
        n_cmp++; if (data_req !== 1'b0 || dmem_busy !== 1'b0 || m_rdata !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL cxl_resp req=%0b busy=%0b rdata=%h want 0/0/0badf00d", data_req, dmem_busy, m_rdata);
        end
        tick();
        drv(0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 1, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b0 || m_rdata !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL cxl_after req=%0b rdata=%h want 0/0badf00d", data_req, m_rdata);
        end
        tick();
    endtask

    task automatic test_store();
        drv(1, 1, 2'd0, 32'h2000_0003, 32'h0000_00AB, 0, 1, 1, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b1 || data_wr !== 1'b1 || data_size !== 2'd0) begin
            n_fail++; $display("FAIL st_bus req=%0b wr=%0b size=%0d want 1/1/0", data_req, data_wr, data_size);
        end
        n_cmp++; if (data_wdata !== 32'h0000_00AB || data_addr !== 32'h2000_0003) begin
            n_fail++; $display("FAIL st_data wdata=%h addr=%h want 000000ab/20000003", data_wdata, data_addr);
        end
        tick();
        drv(1, 1, 2'd0, 32'h2000_0003, 32'h0000_00AB, 0, 0, 0, 1, 32'hFFFF_FFFF);
        n_cmp++; if (dmem_busy !== 1'b0 || m_rdata !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL st_resp busy=%0b rdata=%h want 0/0badf00d", dmem_busy, m_rdata);
        end
        tick();
        drv(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        n_cmp++; if (m_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL st_keep got=%h want=0badf00d", m_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        drv(1, 0, 2'd2, 32'h0000_0300, 32'h0, 0, 1, 1, 0, 32'h0);
        tick();
        drv(1, 0, 2'd2, 32'h0000_0300, 32'h0, 0, 0, 0, 1, 32'h1111_1111);
        n_cmp++; if (m_rdata !== 32'h1111_1111 || dmem_busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_r1 rdata=%h busy=%0b want 11111111/0", m_rdata, dmem_busy);
        end
        tick();
        drv(1, 0, 2'd2, 32'h0000_0304, 32'h0, 0, 1, 1, 0, 32'h0);
        n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h0000_0304 || m_rdata !== 32'h1111_1111) begin
            n_fail++; $display("FAIL b2b_issue2 req=%0b addr=%h rdata=%h want 1/00000304/11111111", data_req, data_addr, m_rdata);
        end
        tick();
        drv(1, 0, 2'd2, 32'h0000_0304, 32'h0, 0, 0, 0, 1, 32'h2222_2222);
        n_cmp++; if (m_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_r2 got=%h want=22222222", m_rdata); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        drv(1, 0, 2'd2, 32'h0000_0500, 32'h0, 0, 1, 1, 0, 32'h0);
        tick();
        drv(1, 0, 2'd2, 32'h0000_0500, 32'h0, 0, 1, 0, 0, 32'h0);
        n_cmp++; if (dmem_busy !== 1'b1) begin n_fail++; $display("FAIL rw_wait got=%0b want=1", dmem_busy); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (dmem_busy !== 1'b0 || data_req !== 1'b0 || m_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rw_async busy=%0b req=%0b rdata=%h want 0/0/0", dmem_busy, data_req, m_rdata);
        end
        tick();
        #2 resetn = 1'b1;
        drv(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h7777_7777);
        n_cmp++; if (dmem_busy !== 1'b0 || data_req !== 1'b0 || m_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rw_stray busy=%0b req=%0b rdata=%h want 0/0/0", dmem_busy, data_req, m_rdata);
        end
        tick();
        drv(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        n_cmp++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL rw_after got=%h want=0", m_rdata); end
        tick();
    endtask

    // Transaction-level model: one in-flight access record, a "still held in M" flag
    // after completion, and the last load value returned.
    task automatic test_random();
        logic        t_live, t_acc, t_wr, held;
        logic [1:0]  t_size;
        logic [31:0] t_addr, t_wdata, last_load;
        logic        r_req, r_wr, r_cxl, r_stall, r_aok, r_dok;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wdata, r_rdata;
        logic        issue, resp, e_req, e_busy, e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata, e_rdata;

        resetn = 1'b0;
        #1;
        tick();
        resetn = 1'b1;
        t_live = 0; t_acc = 0; t_wr = 0; held = 0;
        t_size = 0; t_addr = 0; t_wdata = 0; last_load = 0;

        for (int c = 0; c < 600; c++) begin
            r_req   = ($urandom_range(0, 3) != 0);
            r_wr    = 1'($urandom);
            r_size  = 2'($urandom);
            r_addr  = $urandom;
            r_wdata = $urandom;
            r_cxl   = ($urandom_range(0, 5) == 0);
            r_stall = ($urandom_range(0, 2) == 0);
            r_aok   = 1'($urandom);
            r_dok   = 1'($urandom);
            r_rdata = $urandom;

            issue   = !t_live && !held && r_req && !r_cxl;
            resp    = t_live && t_acc && r_dok;
            e_req   = issue || (t_live && !t_acc);
            e_busy  = e_req || (t_live && t_acc && !r_dok);
            e_wr    = issue ? r_wr : t_wr;
            e_size  = issue ? r_size : t_size;
            e_addr  = issue ? r_addr : t_addr;
            e_wdata = issue ? r_wdata : t_wdata;
            e_rdata = (resp && !t_wr) ? r_rdata : last_load;

            drv(r_req, r_wr, r_size, r_addr, r_wdata, r_cxl, r_stall, r_aok, r_dok, r_rdata);
            n_cmp++; if (data_req !== e_req) begin n_fail++; $display("FAIL rnd_req c=%0d got=%0b want=%0b", c, data_req, e_req); end
            n_cmp++; if (dmem_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%0b want=%0b", c, dmem_busy, e_busy); end
            n_cmp++; if (m_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", c, m_rdata, e_rdata); end
            if (e_req) begin
                n_cmp++;
                if (data_wr !== e_wr || data_size !== e_size || data_addr !== e_addr || data_wdata !== e_wdata) begin
                    n_fail++;
                    $display("FAIL rnd_bus c=%0d got=%0b/%0d/%h/%h want=%0b/%0d/%h/%h", c,
                             data_wr, data_size, data_addr, data_wdata, e_wr, e_size, e_addr, e_wdata);
                end
            end
            tick();

            if (issue) begin
                t_live = 1; t_acc = r_aok; t_wr = r_wr; t_size = r_size;
                t_addr = r_addr; t_wdata = r_wdata;
            end else if (t_live && !t_acc) begin
                t_acc = r_aok;
            end else if (resp) begin
                t_live = 0;
                if (!t_wr) last_load = r_rdata;
                held = r_stall;
            end else if (held && !r_stall) begin
                held = 0;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        resetn = 1'b0;
        m_req = 0; m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_cancel = 0;
        pipe_stall = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        #1;
        test_reset();
        test_load_hit();
        test_delayed_accept();
        test_foreign_stall();
        test_cancel();
        test_store();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
